// File: rtl/pc_fetch_unit_pkg.sv
// pc_fetch_unit_pkg: shared types and constants for the fetch stage
package pc_fetch_unit_pkg;
  typedef enum logic [1:0] {BOOT, FETCH, HOLD} state_e;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] PC_STEP_DEF  = 32'd4;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
endpackage

// File: rtl/pc_fetch_unit_ifid_reg.sv
// ifid_reg: IF/ID pipeline register, priority flush > hold > load
module ifid_reg
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] PC_STEP = PC_STEP_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        hold,
  input  logic        load,
  input  logic [31:0] pc_in,
  input  logic [31:0] instr_in,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr
);
  logic        valid_d, valid_q;
  logic [31:0] pc_d, pc_q, pc_plus4_d, pc_plus4_q, instr_d, instr_q;
  always_comb begin
    valid_d    = valid_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    instr_d    = instr_q;
    if (flush) begin
      valid_d    = 1'b0;
      pc_d       = '0;
      pc_plus4_d = '0;
      instr_d    = NOP_INSTR;
    end else if (!hold && load) begin
      valid_d    = 1'b1;
      pc_d       = pc_in;
      pc_plus4_d = pc_in + PC_STEP;
      instr_d    = instr_in;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      pc_plus4_q <= '0;
      instr_q    <= NOP_INSTR;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      instr_q    <= instr_d;
    end
  end
  assign valid    = valid_q;
  assign pc       = pc_q;
  assign pc_plus4 = pc_plus4_q;
  assign instr    = instr_q;
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: architectural PC, imem req/ack fetch FSM with skid buffer, IF/ID load
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] PC_STEP  = PC_STEP_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic [31:0] pc_seq,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        ifid_valid,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc_plus4,
  output logic [31:0] ifid_instr
);
  state_e      state_d, state_q;
  logic [31:0] pc_d, pc_q, skid_pc_d, skid_pc_q, skid_instr_d, skid_instr_q;
  logic [31:0] load_pc, load_instr;
  logic        skid_valid_d, skid_valid_q, flush, load;
  logic        unused_low_bits;
  assign unused_low_bits = ^redirect_pc[1:0];
  assign pc_seq    = pc_q + PC_STEP;
  assign imem_req  = state_q == FETCH;
  assign imem_addr = pc_q;
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    flush        = 1'b0;
    load         = 1'b0;
    load_pc      = pc_q;
    load_instr   = imem_rdata;
    if (state_q == BOOT) begin
      state_d = FETCH;
    end else if (redirect_valid) begin
      pc_d         = {redirect_pc[31:2], 2'b00};
      flush        = 1'b1;
      skid_valid_d = 1'b0;
      state_d      = FETCH;
    end else if (state_q == FETCH) begin
      if (imem_ack && !stall) begin
        load = 1'b1;
        pc_d = pc_seq;
      end else if (imem_ack) begin
        skid_valid_d = 1'b1;
        skid_pc_d    = pc_q;
        skid_instr_d = imem_rdata;
        state_d      = HOLD;
      end else if (!stall) begin
        flush = 1'b1;
      end
    end else if (!stall) begin
      // drain the word captured while the pipeline was stalled
      load         = skid_valid_q;
      load_pc      = skid_pc_q;
      load_instr   = skid_instr_q;
      pc_d         = skid_pc_q + PC_STEP;
      skid_valid_d = 1'b0;
      state_d      = FETCH;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= '0;
      skid_instr_q <= NOP_INSTR;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
    end
  end
  ifid_reg #(.PC_STEP(PC_STEP)) u_ifid (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .hold    (stall),
    .load    (load),
    .pc_in   (load_pc),
    .instr_in(load_instr),
    .valid   (ifid_valid),
    .pc      (ifid_pc),
    .pc_plus4(ifid_pc_plus4),
    .instr   (ifid_instr)
  );
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed checks of fetch, stall/skid, redirect, wait states, wrap and async reset
module tb_pc_fetch_unit;
  logic        clk, rst_n, redirect_valid, stall, imem_req, imem_ack, ifid_valid;
  logic [31:0] redirect_pc, pc_seq, imem_addr, imem_rdata, ifid_pc, ifid_pc_plus4, ifid_instr;
  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_5000;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  pc_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall(stall), .pc_seq(pc_seq), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .ifid_valid(ifid_valid),
    .ifid_pc(ifid_pc), .ifid_pc_plus4(ifid_pc_plus4), .ifid_instr(ifid_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; stall = 1'b0; imem_ack = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", imem_req); end
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", ifid_valid); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h exp 0", imem_addr); end
    checks++; if ({ifid_pc, ifid_pc_plus4, ifid_instr} !== 96'h0) begin errors++; $display("FAIL rst_ifid got %h %h %h exp 0", ifid_pc, ifid_pc_plus4, ifid_instr); end
    checks++; if (pc_seq !== 32'h4) begin errors++; $display("FAIL rst_pc_seq got %h exp 4", pc_seq); end
    rst_n = 1'b1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL boot_req got %b exp 0", imem_req); end
    tick();
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL fetch_req got %b exp 1", imem_req); end
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL boot_valid got %b exp 0", ifid_valid); end
  endtask

  task automatic test_sequential;
    imem_ack = 1'b1;
    tick();
    checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL seq0_valid got %b exp 1", ifid_valid); end
    checks++; if (ifid_pc !== 32'h0) begin errors++; $display("FAIL seq0_pc got %h exp 0", ifid_pc); end
    checks++; if (ifid_pc_plus4 !== 32'h4) begin errors++; $display("FAIL seq0_plus4 got %h exp 4", ifid_pc_plus4); end
    checks++; if (ifid_instr !== mem_word(32'h0)) begin errors++; $display("FAIL seq0_instr got %h exp %h", ifid_instr, mem_word(32'h0)); end
    checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL seq0_addr got %h exp 4", imem_addr); end
    checks++; if (pc_seq !== 32'h8) begin errors++; $display("FAIL seq0_pc_seq got %h exp 8", pc_seq); end
    tick();
    checks++; if (ifid_pc !== 32'h4) begin errors++; $display("FAIL seq1_pc got %h exp 4", ifid_pc); end
    checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL seq1_addr got %h exp 8", imem_addr); end
  endtask

  task automatic test_stall;
    stall = 1'b1;
    tick();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req got %b exp 0", imem_req); end
    checks++; if (ifid_pc !== 32'h4 || ifid_valid !== 1'b1) begin errors++; $display("FAIL stall_hold got %h/%b exp 4/1", ifid_pc, ifid_valid); end
    imem_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (ifid_pc !== 32'h4 || imem_req !== 1'b0) begin errors++; $display("FAIL stall_hold%0d got pc %h req %b exp 4/0", i, ifid_pc, imem_req); end
    end
    stall = 1'b0;
    tick();
    checks++; if (ifid_pc !== 32'h8 || ifid_valid !== 1'b1) begin errors++; $display("FAIL skid_pc got %h/%b exp 8/1", ifid_pc, ifid_valid); end
    checks++; if (ifid_instr !== mem_word(32'h8)) begin errors++; $display("FAIL skid_instr got %h exp %h", ifid_instr, mem_word(32'h8)); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin errors++; $display("FAIL skid_addr got %b/%h exp 1/c", imem_req, imem_addr); end
    imem_ack = 1'b1;
    tick();
    checks++; if (ifid_pc !== 32'hC) begin errors++; $display("FAIL post_skid_pc got %h exp c", ifid_pc); end
  endtask

  task automatic test_redirect;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0043;
    tick();
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL redir_valid got %b exp 0", ifid_valid); end
    checks++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL redir_addr got %h exp 40", imem_addr); end
    redirect_valid = 1'b0;
    tick();
    checks++; if (ifid_pc !== 32'h40 || ifid_valid !== 1'b1) begin errors++; $display("FAIL redir_pc got %h/%b exp 40/1", ifid_pc, ifid_valid); end
    checks++; if (ifid_instr !== mem_word(32'h40)) begin errors++; $display("FAIL redir_instr got %h exp %h", ifid_instr, mem_word(32'h40)); end
  endtask

  task automatic test_redirect_in_hold;
    stall = 1'b1;
    tick();
    checks++; if (imem_req !== 1'b0 || ifid_pc !== 32'h40) begin errors++; $display("FAIL rh_hold got %b/%h exp 0/40", imem_req, ifid_pc); end
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100; imem_ack = 1'b0;
    tick();
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL rh_flush got %b exp 0", ifid_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL rh_addr got %b/%h exp 1/100", imem_req, imem_addr); end
    redirect_valid = 1'b0; stall = 1'b0; imem_ack = 1'b1;
    tick();
    checks++; if (ifid_pc !== 32'h100 || ifid_valid !== 1'b1) begin errors++; $display("FAIL rh_pc got %h/%b exp 100/1", ifid_pc, ifid_valid); end
    checks++; if (ifid_instr !== mem_word(32'h100)) begin errors++; $display("FAIL rh_stale got %h exp %h", ifid_instr, mem_word(32'h100)); end
  endtask

  task automatic test_slow_mem;
    imem_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (ifid_valid !== 1'b0 || imem_addr !== 32'h104) begin errors++; $display("FAIL wait%0d got %b/%h exp 0/104", i, ifid_valid, imem_addr); end
    end
    imem_ack = 1'b1;
    tick();
    checks++; if (ifid_pc !== 32'h104 || ifid_valid !== 1'b1) begin errors++; $display("FAIL wait_ack got %h/%b exp 104/1", ifid_pc, ifid_valid); end
    checks++; if (imem_addr !== 32'h108) begin errors++; $display("FAIL wait_addr got %h exp 108", imem_addr); end
  endtask

  task automatic test_wrap;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    tick();
    checks++; if (imem_addr !== 32'hFFFF_FFFC || pc_seq !== 32'h0) begin errors++; $display("FAIL wrap_addr got %h/%h exp fffffffc/0", imem_addr, pc_seq); end
    redirect_valid = 1'b0;
    tick();
    checks++; if (ifid_pc !== 32'hFFFF_FFFC || ifid_pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_ifid got %h/%h exp fffffffc/0", ifid_pc, ifid_pc_plus4); end
    checks++; if (imem_addr !== 32'h0 || pc_seq !== 32'h4) begin errors++; $display("FAIL wrap_pc got %h/%h exp 0/4", imem_addr, pc_seq); end
    tick();
    checks++; if (ifid_pc !== 32'h0 || ifid_pc_plus4 !== 32'h4) begin errors++; $display("FAIL wrap_next got %h/%h exp 0/4", ifid_pc, ifid_pc_plus4); end
  endtask

  task automatic test_stall_bubble;
    imem_ack = 1'b0;
    tick();
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL bub_valid got %b exp 0", ifid_valid); end
    stall = 1'b1; imem_ack = 1'b1;
    tick();
    checks++; if (ifid_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL bub_hold got %b/%b exp 0/0", ifid_valid, imem_req); end
    stall = 1'b0; imem_ack = 1'b0;
    tick();
    checks++; if (ifid_pc !== 32'h4 || ifid_valid !== 1'b1) begin errors++; $display("FAIL bub_drain got %h/%b exp 4/1", ifid_pc, ifid_valid); end
    checks++; if (ifid_instr !== mem_word(32'h4) || imem_addr !== 32'h8) begin errors++; $display("FAIL bub_instr got %h/%h exp %h/8", ifid_instr, imem_addr, mem_word(32'h4)); end
  endtask

  task automatic test_async_reset;
    stall = 1'b1; imem_ack = 1'b1;
    tick();
    checks++; if (imem_req !== 1'b0 || ifid_valid !== 1'b1) begin errors++; $display("FAIL ar_hold got %b/%b exp 0/1", imem_req, ifid_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ifid_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL ar_ctl got %b/%b exp 0/0", ifid_valid, imem_req); end
    checks++; if ({ifid_pc, ifid_pc_plus4, ifid_instr} !== 96'h0) begin errors++; $display("FAIL ar_ifid got %h %h %h exp 0", ifid_pc, ifid_pc_plus4, ifid_instr); end
    checks++; if (imem_addr !== 32'h0 || pc_seq !== 32'h4) begin errors++; $display("FAIL ar_pc got %h/%h exp 0/4", imem_addr, pc_seq); end
    @(negedge clk);
    rst_n = 1'b1; stall = 1'b0; imem_ack = 1'b1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL ar_boot got %b exp 0", imem_req); end
    tick();
    checks++; if (imem_req !== 1'b1 || ifid_valid !== 1'b0) begin errors++; $display("FAIL ar_fetch got %b/%b exp 1/0", imem_req, ifid_valid); end
    tick();
    checks++; if (ifid_pc !== 32'h0 || ifid_valid !== 1'b1) begin errors++; $display("FAIL ar_first got %h/%b exp 0/1", ifid_pc, ifid_valid); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_redirect_in_hold();
    test_slow_mem();
    test_wrap();
    test_stall_bubble();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
